bf_io_controller: RTL and testbench

Byte-stream I/O controller for the Brainfuck processor core. It buffers host input bytes in an input FIFO that feeds the core's `data_in`/`data_available` port and retires them on the core's `data_read` pulse. It captures the core's `data_out`/`data_out_en` writes into an output FIFO that drains to the host over a valid/ready handshake. Because the core cannot stall on output, overflow drops the byte and records sticky status.

---
 rtl/bf_io_controller_if.sv | 39 +++
 rtl/bf_io_controller.sv | 96 +++++++++
 tb/tb_bf_io_controller.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/bf_io_controller_if.sv
// Bundles the host byte streams, core I/O port and status of bf_io_controller.
// The slave modport is the controller side; master is the host/core side.
interface bf_io_controller_if #(
    parameter int unsigned DATA_WIDTH      = 8,
    parameter int unsigned FIFO_ADDR_WIDTH = 4
);
    localparam int unsigned CW = FIFO_ADDR_WIDTH + 1;

    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] cpu_data_in;
    logic                  cpu_data_available;
    logic                  cpu_data_read;
    logic [DATA_WIDTH-1:0] cpu_data_out;
    logic                  cpu_data_out_en;
    logic [CW-1:0]         in_count;
    logic [CW-1:0]         out_count;
    logic                  out_overflow;
    logic                  read_underflow;
    logic                  clear_status;

    modport slave (
        input  in_data, in_valid, out_ready, cpu_data_read, cpu_data_out,
               cpu_data_out_en, clear_status,
        output in_ready, out_data, out_valid, cpu_data_in, cpu_data_available,
               in_count, out_count, out_overflow, read_underflow
    );

    modport master (
        output in_data, in_valid, out_ready, cpu_data_read, cpu_data_out,
               cpu_data_out_en, clear_status,
        input  in_ready, out_data, out_valid, cpu_data_in, cpu_data_available,
               in_count, out_count, out_overflow, read_underflow
    );
endinterface

// File: rtl/bf_io_controller.sv
// Byte-stream I/O controller: host->core input FIFO and core->host output FIFO
// with sticky overflow/underflow status. Output overflow drops the byte.
module bf_io_controller #(
    parameter int unsigned DATA_WIDTH      = 8,
    parameter int unsigned FIFO_ADDR_WIDTH = 4
) (
    input logic                clk,
    input logic                rst_n,
    bf_io_controller_if.slave  bus
);
    localparam int unsigned DEPTH = 1 << FIFO_ADDR_WIDTH;
    localparam int unsigned CW    = FIFO_ADDR_WIDTH + 1;
    localparam int unsigned AW    = FIFO_ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] in_mem  [DEPTH];
    logic [DATA_WIDTH-1:0] out_mem [DEPTH];

    logic [AW-1:0] in_wr_ptr, in_rd_ptr, out_wr_ptr, out_rd_ptr;
    logic [CW-1:0] in_count_q, out_count_q;
    logic [CW-1:0] in_count_d, out_count_d;
    logic          in_ready_q, in_avail_q, out_valid_q;
    logic          ovf_q, und_q;

    logic in_push, in_pop, out_push, out_pop, out_full;
    logic ovf_set, und_set;

    // Transfer decisions; only out_ready reaches the output accept path combinationally.
    always_comb begin
        in_push  = bus.in_valid && in_ready_q;
        in_pop   = bus.cpu_data_read && in_avail_q;
        und_set  = bus.cpu_data_read && !in_avail_q;
        out_pop  = out_valid_q && bus.out_ready;
        out_full = (out_count_q == CW'(DEPTH));
        out_push = bus.cpu_data_out_en && (!out_full || out_pop);
        ovf_set  = bus.cpu_data_out_en && out_full && !out_pop;

        in_count_d = in_count_q;
        case ({in_push, in_pop})
            2'b10:   in_count_d = in_count_q + CW'(1);
            2'b01:   in_count_d = in_count_q - CW'(1);
            default: in_count_d = in_count_q;
        endcase

        out_count_d = out_count_q;
        case ({out_push, out_pop})
            2'b10:   out_count_d = out_count_q + CW'(1);
            2'b01:   out_count_d = out_count_q - CW'(1);
            default: out_count_d = out_count_q;
        endcase
    end

    // Pointers, counts, registered status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_wr_ptr   <= '0;
            in_rd_ptr   <= '0;
            out_wr_ptr  <= '0;
            out_rd_ptr  <= '0;
            in_count_q  <= '0;
            out_count_q <= '0;
            in_ready_q  <= 1'b0;
            in_avail_q  <= 1'b0;
            out_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
            und_q       <= 1'b0;
        end else begin
            if (in_push)  in_wr_ptr  <= in_wr_ptr + AW'(1);
            if (in_pop)   in_rd_ptr  <= in_rd_ptr + AW'(1);
            if (out_push) out_wr_ptr <= out_wr_ptr + AW'(1);
            if (out_pop)  out_rd_ptr <= out_rd_ptr + AW'(1);
            in_count_q  <= in_count_d;
            out_count_q <= out_count_d;
            in_ready_q  <= (in_count_d != CW'(DEPTH));
            in_avail_q  <= (in_count_d != '0);
            out_valid_q <= (out_count_d != '0);
            ovf_q       <= ovf_set || (ovf_q && !bus.clear_status);
            und_q       <= und_set || (und_q && !bus.clear_status);
        end
    end

    // Storage is intentionally not reset.
    always_ff @(posedge clk) begin
        if (in_push)  in_mem[in_wr_ptr]   <= bus.in_data;
        if (out_push) out_mem[out_wr_ptr] <= bus.cpu_data_out;
    end

    assign bus.in_ready           = in_ready_q;
    assign bus.cpu_data_available = in_avail_q;
    assign bus.cpu_data_in        = in_mem[in_rd_ptr];
    assign bus.out_valid          = out_valid_q;
    assign bus.out_data           = out_mem[out_rd_ptr];
    assign bus.in_count           = in_count_q;
    assign bus.out_count          = out_count_q;
    assign bus.out_overflow       = ovf_q;
    assign bus.read_underflow     = und_q;
endmodule

// File: tb/tb_bf_io_controller.sv
// Directed and randomized bench for bf_io_controller with queue scoreboards
// for both byte streams and a reference model of counts and sticky flags.
module tb_bf_io_controller;
    localparam int unsigned DW    = 8;
    localparam int unsigned AW    = 4;
    localparam int unsigned DEPTH = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bf_io_controller_if #(.DATA_WIDTH(DW), .FIFO_ADDR_WIDTH(AW)) bus ();

    bf_io_controller #(.DATA_WIDTH(DW), .FIFO_ADDR_WIDTH(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] in_exp  [$];
    logic [DW-1:0] out_exp [$];
    logic m_ovf = 1'b0;
    logic m_und = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.in_data         = '0;
        bus.in_valid        = 1'b0;
        bus.out_ready       = 1'b0;
        bus.cpu_data_read   = 1'b0;
        bus.cpu_data_out    = '0;
        bus.cpu_data_out_en = 1'b0;
        bus.clear_status    = 1'b0;
    endtask

    // One clock with the currently driven inputs; scoreboard and model update around the edge.
    task automatic cycle();
        logic in_full, out_full, out_pop, set_o, set_u;
        in_full  = (in_exp.size() == DEPTH);
        out_full = (out_exp.size() == DEPTH);
        set_u    = bus.cpu_data_read && (in_exp.size() == 0);
        if (bus.cpu_data_read && in_exp.size() != 0) begin
            chk("cpu_data_in", 32'(bus.cpu_data_in), 32'(in_exp[0]));
            void'(in_exp.pop_front());
        end
        if (bus.in_valid && !in_full) in_exp.push_back(bus.in_data);
        out_pop = bus.out_ready && (out_exp.size() != 0);
        if (out_pop) begin
            chk("out_data", 32'(bus.out_data), 32'(out_exp[0]));
            void'(out_exp.pop_front());
        end
        set_o = bus.cpu_data_out_en && out_full && !out_pop;
        if (bus.cpu_data_out_en && !set_o) out_exp.push_back(bus.cpu_data_out);
        m_ovf = set_o || (m_ovf && !bus.clear_status);
        m_und = set_u || (m_und && !bus.clear_status);
        @(posedge clk);
        #1;
        chk("in_count",           32'(bus.in_count),           32'(in_exp.size()));
        chk("out_count",          32'(bus.out_count),          32'(out_exp.size()));
        chk("in_ready",           32'(bus.in_ready),           32'(in_exp.size() != DEPTH));
        chk("cpu_data_available", 32'(bus.cpu_data_available), 32'(in_exp.size() != 0));
        chk("out_valid",          32'(bus.out_valid),          32'(out_exp.size() != 0));
        chk("out_overflow",       32'(bus.out_overflow),       32'(m_ovf));
        chk("read_underflow",     32'(bus.read_underflow),     32'(m_und));
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_in_count"},  32'(bus.in_count),           32'd0);
        chk({tag, "_out_count"}, 32'(bus.out_count),          32'd0);
        chk({tag, "_out_valid"}, 32'(bus.out_valid),          32'd0);
        chk({tag, "_avail"},     32'(bus.cpu_data_available), 32'd0);
        chk({tag, "_in_ready"},  32'(bus.in_ready),           32'd0);
        chk({tag, "_ovf"},       32'(bus.out_overflow),       32'd0);
        chk({tag, "_und"},       32'(bus.read_underflow),     32'd0);
    endtask

    initial begin
        idle_inputs();
        #1;
        check_reset_outputs("por");
        #11 rst_n = 1'b1;
        chk("pre_edge_in_ready", 32'(bus.in_ready), 32'd0);
        @(posedge clk);
        #1;
        chk("first_edge_in_ready", 32'(bus.in_ready), 32'd1);

        // Input ordering: core reads one per cycle starting after first push.
        bus.in_valid = 1'b1; bus.in_data = 8'h2B; cycle();
        bus.in_data = 8'h00; bus.cpu_data_read = 1'b1; cycle();
        bus.in_data = 8'hFF; cycle();
        bus.in_valid = 1'b0; cycle();
        idle_inputs(); cycle();

        // Input full: 17 offers, the last is refused.
        for (int i = 0; i < 17; i++) begin
            bus.in_valid = 1'b1; bus.in_data = 8'(8'h80 + i); cycle();
        end
        chk("full_in_count", 32'(bus.in_count), 32'd16);
        chk("full_in_ready", 32'(bus.in_ready), 32'd0);
        idle_inputs(); bus.cpu_data_read = 1'b1; cycle();
        chk("after_read_in_count", 32'(bus.in_count), 32'd15);
        chk("after_read_in_ready", 32'(bus.in_ready), 32'd1);
        for (int i = 0; i < 15; i++) cycle();
        idle_inputs();

        // Pointer wrap: 40 bytes streamed through the input FIFO.
        for (int i = 0; i < 40; i++) begin
            bus.in_valid = 1'b1; bus.in_data = 8'(8'h40 + i);
            bus.cpu_data_read = (in_exp.size() != 0);
            cycle();
        end
        bus.in_valid = 1'b0;
        for (int i = 0; i < 20 && in_exp.size() != 0; i++) begin
            bus.cpu_data_read = 1'b1; cycle();
        end
        idle_inputs();
        chk("wrap_drained", 32'(in_exp.size()), 32'd0);

        // Output overflow: 17 writes with host stalled.
        for (int i = 0; i < 17; i++) begin
            bus.cpu_data_out_en = 1'b1; bus.cpu_data_out = 8'(i); cycle();
        end
        chk("ovf_out_count", 32'(bus.out_count), 32'd16);
        chk("ovf_flag", 32'(bus.out_overflow), 32'd1);
        idle_inputs();
        for (int i = 0; i < 20 && out_exp.size() != 0; i++) begin
            bus.out_ready = 1'b1; cycle();
        end
        idle_inputs();
        chk("ovf_drained", 32'(out_exp.size()), 32'd0);
        bus.clear_status = 1'b1; cycle();
        idle_inputs();
        chk("ovf_cleared", 32'(bus.out_overflow), 32'd0);

        // Full output FIFO with a simultaneous pop accepts the 17th byte.
        for (int i = 0; i < 16; i++) begin
            bus.cpu_data_out_en = 1'b1; bus.cpu_data_out = 8'(8'h20 + i); cycle();
        end
        bus.cpu_data_out = 8'h30; bus.out_ready = 1'b1; cycle();
        chk("nodrop_flag", 32'(bus.out_overflow), 32'd0);
        chk("nodrop_count", 32'(bus.out_count), 32'd16);
        idle_inputs();
        for (int i = 0; i < 20 && out_exp.size() != 0; i++) begin
            bus.out_ready = 1'b1; cycle();
        end
        idle_inputs();

        // Underflow and clear priority.
        bus.cpu_data_read = 1'b1; cycle();
        chk("und_set", 32'(bus.read_underflow), 32'd1);
        bus.clear_status = 1'b1; cycle();
        chk("und_set_beats_clear", 32'(bus.read_underflow), 32'd1);
        bus.cpu_data_read = 1'b0; cycle();
        chk("und_cleared", 32'(bus.read_underflow), 32'd0);
        idle_inputs(); cycle();

        // Concurrent streaming with the core echoing every input byte.
        for (int i = 0; i < 400; i++) begin
            idle_inputs();
            bus.in_valid  = 1'($urandom_range(0, 1));
            bus.in_data   = 8'($urandom_range(0, 255));
            bus.out_ready = 1'($urandom_range(0, 1));
            if (in_exp.size() != 0 && out_exp.size() < DEPTH) begin
                bus.cpu_data_read   = 1'b1;
                bus.cpu_data_out_en = 1'b1;
                bus.cpu_data_out    = in_exp[0];
            end
            cycle();
        end
        for (int i = 0; i < 100 && (in_exp.size() != 0 || out_exp.size() != 0); i++) begin
            idle_inputs();
            bus.out_ready = 1'b1;
            if (in_exp.size() != 0 && out_exp.size() < DEPTH) begin
                bus.cpu_data_read   = 1'b1;
                bus.cpu_data_out_en = 1'b1;
                bus.cpu_data_out    = in_exp[0];
            end
            cycle();
        end
        idle_inputs();
        chk("stream_in_drained",  32'(in_exp.size()),  32'd0);
        chk("stream_out_drained", 32'(out_exp.size()), 32'd0);

        // Reset mid-stream with 5 bytes queued in each FIFO.
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = 1'b1; bus.in_data = 8'(8'hA0 + i);
            bus.cpu_data_out_en = 1'b1; bus.cpu_data_out = 8'(8'hB0 + i);
            cycle();
        end
        chk("pre_reset_in_count",  32'(bus.in_count),  32'd5);
        chk("pre_reset_out_count", 32'(bus.out_count), 32'd5);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_rst");
        in_exp.delete(); out_exp.delete(); m_ovf = 1'b0; m_und = 1'b0;
        @(posedge clk);
        #1;
        check_reset_outputs("held_rst");
        #2 rst_n = 1'b1;
        idle_inputs();
        @(posedge clk);
        #1;
        chk("rel_in_ready",  32'(bus.in_ready),  32'd1);
        chk("rel_in_count",  32'(bus.in_count),  32'd0);
        chk("rel_out_count", 32'(bus.out_count), 32'd0);
        bus.in_valid = 1'b1; bus.in_data = 8'h5A; cycle();
        idle_inputs(); bus.cpu_data_read = 1'b1; cycle();
        idle_inputs(); cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
